udma_pattern_gen_rx: RTL and testbench

Parametrised RX-side traffic generator for uDMA channel bring-up and bandwidth characterisation. It produces a programmable-length burst on a valid/ready stream into the uDMA RX channel, using one of three data patterns: incrementing with step, constant, or Galois LFSR. Configurable inter-word gap cycles emulate slow peripherals. It reports progress and completion to the register file and is the successor of the fixed 32-bit, increment-only generator.

---
 rtl/udma_pattern_gen_rx.sv | 198 +++++++++++++++++++
 tb/tb_udma_pattern_gen_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_pattern_gen_rx.sv
// udma_pattern_gen_rx: RX-side stream traffic generator for uDMA bring-up.
// Emits a programmable-length burst of INC / CONST / LFSR data words on a
// valid/ready stream, with optional idle gap cycles after every accepted word.
module udma_pattern_gen_rx #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           CNT_WIDTH  = 16,
    parameter int unsigned           GAP_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(32'h8020_0003)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [CNT_WIDTH-1:0]  cfg_len_i,
    input  logic [DATA_WIDTH-1:0] cfg_seed_i,
    input  logic [DATA_WIDTH-1:0] cfg_step_i,
    input  logic [GAP_WIDTH-1:0]  cfg_gap_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  count_o
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GEN        = 2'd1,
        ST_GAP        = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } state_e;

    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd2;

    // Next word of the sequence; mode 1 and the reserved mode 3 repeat the word.
    function automatic logic [DATA_WIDTH-1:0] next_data(
        input logic [1:0]            mode,
        input logic [DATA_WIDTH-1:0] data,
        input logic [DATA_WIDTH-1:0] step
    );
        logic [DATA_WIDTH-1:0] res;
        case (mode)
            MODE_INC:  res = data + step;
            MODE_LFSR: res = (data >> 1) ^ (data[0] ? LFSR_POLY : {DATA_WIDTH{1'b0}});
            default:   res = data;
        endcase
        return res;
    endfunction

    state_e                state_r, state_next_s;
    logic [1:0]            mode_r;
    logic [CNT_WIDTH-1:0]  len_r;
    logic [DATA_WIDTH-1:0] step_r;
    logic [GAP_WIDTH-1:0]  gap_r;
    logic [GAP_WIDTH-1:0]  gap_cnt_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  valid_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  start_s;
    logic                  accept_s;
    logic                  last_s;
    logic                  done_set_s;
    logic [DATA_WIDTH-1:0] seed_load_s;

    // The word being accepted is the last one of the burst.
    assign last_s = (count_r == (len_r - CNT_WIDTH'(1)));

    // State register plus outputs registered from the next state so valid/busy are glitch-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            valid_r <= (state_next_s == ST_GEN);
            busy_r  <= (state_next_s == ST_GEN) || (state_next_s == ST_GAP);
            done_r  <= done_set_s;
        end
    end

    // Next-state decision; a handshake completing the burst wins over an abort.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_en_i) begin
                    if (cfg_len_i == {CNT_WIDTH{1'b0}}) begin
                        state_next_s = ST_WAIT_CLEAR;
                    end else begin
                        state_next_s = ST_GEN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GEN: begin
                if (rx_ready_i) begin
                    if (last_s) begin
                        state_next_s = ST_WAIT_CLEAR;
                    end else if (!cfg_en_i) begin
                        state_next_s = ST_IDLE;
                    end else if (gap_r != {GAP_WIDTH{1'b0}}) begin
                        state_next_s = ST_GAP;
                    end else begin
                        state_next_s = ST_GEN;
                    end
                end else begin
                    state_next_s = ST_GEN;
                end
            end
            ST_GAP: begin
                if (!cfg_en_i) begin
                    state_next_s = ST_IDLE;
                end else if (gap_cnt_r <= GAP_WIDTH'(1)) begin
                    state_next_s = ST_GEN;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            ST_WAIT_CLEAR: begin
                if (!cfg_en_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_CLEAR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Event decode for the datapath: burst start, word acceptance, completion.
    always_comb begin
        start_s     = 1'b0;
        accept_s    = 1'b0;
        done_set_s  = 1'b0;
        seed_load_s = cfg_seed_i;
        case (state_r)
            ST_IDLE: begin
                start_s    = cfg_en_i;
                done_set_s = cfg_en_i && (cfg_len_i == {CNT_WIDTH{1'b0}});
            end
            ST_GEN: begin
                accept_s   = rx_ready_i;
                done_set_s = rx_ready_i && last_s;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
        // An all-zero LFSR state would lock up, so seed 0 starts from 1.
        if ((cfg_mode_i == MODE_LFSR) && (cfg_seed_i == {DATA_WIDTH{1'b0}})) begin
            seed_load_s = DATA_WIDTH'(1);
        end else begin
            seed_load_s = cfg_seed_i;
        end
    end

    // Configuration latch, data sequence, word counter and gap counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_r    <= 2'd0;
            len_r     <= {CNT_WIDTH{1'b0}};
            step_r    <= {DATA_WIDTH{1'b0}};
            gap_r     <= {GAP_WIDTH{1'b0}};
            gap_cnt_r <= {GAP_WIDTH{1'b0}};
            data_r    <= {DATA_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
        end else if (start_s) begin
            mode_r  <= cfg_mode_i;
            len_r   <= cfg_len_i;
            step_r  <= cfg_step_i;
            gap_r   <= cfg_gap_i;
            data_r  <= seed_load_s;
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            count_r   <= count_r + CNT_WIDTH'(1);
            data_r    <= next_data(mode_r, data_r, step_r);
            gap_cnt_r <= gap_r;
        end else if (state_r == ST_GAP) begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    assign rx_data_o  = data_r;
    assign rx_valid_o = valid_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign count_o    = count_r;

endmodule

// File: tb/tb_udma_pattern_gen_rx.sv
// Self-checking bench for udma_pattern_gen_rx: directed scenarios plus
// randomized bursts compared against an arithmetic reference model.
module tb_udma_pattern_gen_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_len;
    logic [31:0] cfg_seed;
    logic [31:0] cfg_step;
    logic [7:0]  cfg_gap;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic [15:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    udma_pattern_gen_rx dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_en_i   (cfg_en),
        .cfg_mode_i (cfg_mode),
        .cfg_len_i  (cfg_len),
        .cfg_seed_i (cfg_seed),
        .cfg_step_i (cfg_step),
        .cfg_gap_i  (cfg_gap),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Word number idx of a burst, computed directly from the pattern rules.
    function automatic logic [31:0] model_word(input int mode, input logic [31:0] seed,
                                               input logic [31:0] step, input int idx);
        logic [31:0] w;
        if (mode == 0) begin
            w = seed + step * 32'(idx);
        end else if (mode == 2) begin
            w = (seed == 32'd0) ? 32'd1 : seed;
            repeat (idx) w = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
        end else begin
            w = seed;
        end
        return w;
    endfunction

    // Runs one burst with ready asserted rdy_pct percent of the time and checks it.
    task automatic run_burst(input int mode, input int len, input logic [31:0] seed,
                             input logic [31:0] step, input int gap, input int rdy_pct,
                             input int hold);
        int acc = 0;
        int idle_run = 0;
        int cyc = 0;
        bit seen_hs = 1'b0;
        bit finished = 1'b0;
        bit first = 1'b1;
        bit rd;
        bit any_valid = 1'b0;
        bit any_done = 1'b0;
        @(negedge clk);
        cfg_mode = mode[1:0];
        cfg_len  = len[15:0];
        cfg_seed = seed;
        cfg_step = step;
        cfg_gap  = gap[7:0];
        cfg_en   = 1'b1;
        rx_ready = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // Config changes after start must be ignored.
            cfg_seed = $urandom;
            cfg_step = $urandom;
            cfg_gap  = 8'($urandom_range(0, 5));
            cfg_len  = 16'($urandom_range(0, 20));
            if (first) begin
                chk("first_valid", rx_valid, (len != 0));
                first = 1'b0;
            end
            if (done) begin
                chk("done_count", count, len);
                chk("done_busy", busy, 0);
                chk("done_valid", rx_valid, 0);
                chk("accepted", acc, len);
                finished = 1'b1;
            end else begin
                if (rx_valid) begin
                    chk("data", rx_data, model_word(mode, seed, step, acc));
                    if (seen_hs) begin
                        chk("gap_len", idle_run, gap);
                        seen_hs = 1'b0;
                    end
                end else if (seen_hs) begin
                    idle_run++;
                end else begin
                    idle_run = 0;
                end
                rd = ($urandom_range(1, 100) <= rdy_pct);
                rx_ready = rd;
                if (rx_valid && rd) begin
                    acc++;
                    seen_hs = 1'b1;
                    idle_run = 0;
                end
            end
        end
        chk("burst_done", finished, 1);
        rx_ready = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            any_valid |= rx_valid;
            any_done  |= done;
        end
        chk("no_restart_valid", any_valid, 0);
        chk("single_done", any_done, 0);
        chk("hold_count", count, len);
        if (len != 0) chk("hold_data", rx_data, model_word(mode, seed, step, len));
        cfg_en = 1'b0;
        rx_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_en = 1'b0;
        cfg_mode = 2'd0;
        cfg_len = 16'd0;
        cfg_seed = 32'd0;
        cfg_step = 32'd0;
        cfg_gap = 8'd0;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", rx_valid, 0);

        // Directed scenarios from the plan.
        run_burst(0, 4, 32'h10, 32'h4, 0, 100, 2);
        run_burst(0, 3, 32'hFFFF_FFFE, 32'h1, 0, 50, 2);
        run_burst(2, 2, 32'h0, 32'h0, 0, 100, 1);
        chk("lfsr_ref", model_word(2, 32'h0, 32'h0, 1), 32'h8020_0003);
        run_burst(1, 3, 32'hA5A5_A5A5, 32'h7, 0, 70, 1);
        run_burst(0, 3, 32'h100, 32'h3, 2, 100, 1);
        run_burst(0, 0, 32'h5, 32'h1, 0, 100, 4);
        run_burst(3, 4, 32'h1234_5678, 32'h9, 1, 60, 1);

        // Randomized bursts.
        for (int i = 0; i < 24; i++) begin
            run_burst($urandom_range(0, 3), $urandom_range(0, 12), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(1, 3));
        end

        // Abort in GEN: valid held without ready, then one word accepted, no done.
        @(negedge clk);
        cfg_mode = 2'd1; cfg_len = 16'd5; cfg_seed = 32'h55; cfg_gap = 8'd0;
        cfg_en = 1'b1; rx_ready = 1'b0;
        @(negedge clk);
        chk("abort_valid", rx_valid, 1);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("abort_hold_valid", rx_valid, 1);
        chk("abort_hold_data", rx_data, 32'h55);
        rx_ready = 1'b1;
        @(negedge clk);
        chk("abort_idle_valid", rx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 1);
        chk("abort_no_done", done, 0);
        rx_ready = 1'b0;
        @(negedge clk);
        chk("abort_no_done2", done, 0);

        // Abort in GAP returns to IDLE on the next edge.
        cfg_mode = 2'd0; cfg_len = 16'd4; cfg_seed = 32'h1; cfg_step = 32'h1;
        cfg_gap = 8'd4; cfg_en = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        chk("gap_abort_valid", rx_valid, 1);
        @(negedge clk);
        chk("gap_abort_in_gap", busy, 1);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("gap_abort_idle", busy, 0);
        chk("gap_abort_count", count, 1);
        chk("gap_abort_no_done", done, 0);

        // Last word and enable drop in the same cycle: completion wins.
        cfg_mode = 2'd0; cfg_len = 16'd2; cfg_seed = 32'h1; cfg_step = 32'h1;
        cfg_gap = 8'd0; cfg_en = 1'b1; rx_ready = 1'b1;
        @(negedge clk);
        chk("cw_first", rx_data, 32'h1);
        @(negedge clk);
        chk("cw_second", rx_data, 32'h2);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("cw_done", done, 1);
        chk("cw_count", count, 2);
        @(negedge clk);
        chk("cw_done_low", done, 0);
        chk("cw_idle", busy, 0);

        // Reset mid-burst drops valid immediately.
        cfg_len = 16'd10; cfg_en = 1'b1; rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", rx_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        cfg_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_valid", rx_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
